// File: rtl/huffman_bit_serializer.sv
// rtl/huffman_bit_serializer.sv - word FIFO feeding an MSB-first bit serializer with ready/valid output
// Optional trailing even-parity bit per frame when HUFFMAN_SER_PARITY_EN is defined.
module huffman_bit_serializer #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [WORD_W-1:0]             word_in,
  input  logic                          word_valid,
  output logic                          bit_out,
  output logic                          bit_valid,
  input  logic                          bit_ready,
  output logic                          word_done,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WORD_W);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef HUFFMAN_SER_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] head;
  logic              xfer;
  logic              frame_done;
  logic              nonempty;
  logic              full;
  logic              pop;
  logic              push;
`ifdef HUFFMAN_SER_PARITY_EN
  logic              parity_bit;
`endif

  assign head      = mem[rd_ptr];
  assign bit_valid = (state != IDLE);
  assign xfer      = bit_valid & bit_ready;
  assign nonempty  = (level != '0);
  assign full      = (level == LW'(FIFO_DEPTH));
  assign busy      = (state != IDLE) || nonempty;

`ifdef HUFFMAN_SER_PARITY_EN
  assign frame_done = (state == PARITY) && xfer;
  assign bit_out    = (state == PARITY) ? parity_bit : shreg[WORD_W-1];
`else
  assign frame_done = (state == SHIFT) && xfer && (cnt == '0);
  assign bit_out    = shreg[WORD_W-1];
`endif

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop  = nonempty && ((state == IDLE) || frame_done);
  assign push = word_valid && (!full || pop);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= word_in;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      shreg     <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      word_done <= 1'b0;
`ifdef HUFFMAN_SER_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      word_done <= frame_done;
      if (word_valid && !push) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
`ifdef HUFFMAN_SER_PARITY_EN
      if (pop) parity_bit <= ^head;
`endif
      case (state)
        IDLE: begin
          if (pop) begin
            shreg <= head;
            cnt   <= CW'(WORD_W - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (cnt != '0) begin
              shreg <= shreg << 1;
              cnt   <= cnt - CW'(1);
            end else begin
`ifdef HUFFMAN_SER_PARITY_EN
              shreg <= shreg << 1;
              state <= PARITY;
`else
              if (pop) begin
                shreg <= head;
                cnt   <= CW'(WORD_W - 1);
              end else begin
                shreg <= shreg << 1;
                state <= IDLE;
              end
`endif
            end
          end
        end
`ifdef HUFFMAN_SER_PARITY_EN
        PARITY: begin
          if (xfer) begin
            if (pop) begin
              shreg <= head;
              cnt   <= CW'(WORD_W - 1);
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
